adc_scan_seq: RTL

//  Parametrised N-channel ADC scan sequencer. It replaces the fixed 3-channel round-robin capture used with the adc wrapper.
//  On each trigger (e.g. ps_pwm adc_trigger_o), it converts every channel enabled in a mask, in ascending order.
//  Per-channel results are held in registers. The block flags stale channels and ADC stalls, and pulses scan_done_o for the controller clk_enable.

---
 rtl/adc_scan_seq_pkg.sv | 9 +
 rtl/adc_scan_seq_if.sv | 13 +
 rtl/adc_scan_seq_next_ch.sv | 20 ++
 rtl/adc_scan_seq.sv | 109 ++++++++++
 4 files changed

// File: rtl/adc_scan_seq_pkg.sv
// adc_scan_pkg: shared FSM encoding and defaults for the ADC scan sequencer.
package adc_scan_pkg;
  typedef enum logic [1:0] {IDLE, CONV, STORE, DONE} state_e;
  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned DEF_TIMEOUT = 4096;
  function automatic int unsigned ch_w(input int unsigned n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/adc_scan_seq_if.sv
// adc_scan_seq_if: conversion handshake between the scan sequencer and the adc wrapper.
interface adc_scan_seq_if import adc_scan_pkg::*; #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned DATA_W = DEF_DATA_W
);
  localparam int unsigned CH_W = ch_w(NUM_CH);
  logic              adc_start;
  logic [CH_W-1:0]   adc_channel;
  logic [DATA_W-1:0] adc_data;
  logic              adc_drdy;
  modport master (output adc_start, adc_channel, input adc_data, adc_drdy);
  modport slave (input adc_start, adc_channel, output adc_data, adc_drdy);
endinterface

// File: rtl/adc_scan_seq_next_ch.sv
// adc_scan_next_ch: lowest set mask bit strictly above idx_i, with a found flag.
module adc_scan_next_ch import adc_scan_pkg::*; #(
  parameter int unsigned NUM_CH = 3,
  localparam int unsigned CH_W = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [CH_W-1:0]   idx_i,
  output logic [CH_W-1:0]   nxt_o,
  output logic              found_o
);
  always_comb begin
    nxt_o = '0;
    found_o = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (mask_i[k] && k > int'(idx_i)) begin
        nxt_o = CH_W'(k);
        found_o = 1'b1;
      end
  end
endmodule

// File: rtl/adc_scan_seq.sv
// adc_scan_seq: N-channel masked ADC scan sequencer with stale/timeout flags.
// Define ADC_SCAN_AVG_EN to average 2**AVG_LOG2 samples per channel.
module adc_scan_seq import adc_scan_pkg::*; #(
  parameter int unsigned NUM_CH         = 3,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT,
  parameter int unsigned AVG_LOG2       = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     trig_i,
  input  logic [NUM_CH-1:0]        ch_mask_i,
  input  logic                     err_clr_i,
  adc_scan_seq_if.master           adc,
  output logic [NUM_CH*DATA_W-1:0] meas_o,
  output logic [NUM_CH-1:0]        meas_valid_o,
  output logic                     scan_done_o,
  output logic                     busy_o,
  output logic                     timeout_o,
  output logic                     trig_ovr_o
);
  localparam int unsigned CH_W = ch_w(NUM_CH);
  localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES) + 1;
  state_e state_q, state_d;
  logic [NUM_CH-1:0] mask_q;
  logic [CH_W-1:0] ch_q, ch_d, nxt_ch, up_ch, first_ch;
  logic nxt_found, up_found;
  logic [TW-1:0] wait_q;
  logic [NUM_CH*DATA_W-1:0] meas_q;
  logic [NUM_CH-1:0] valid_q;
  logic timeout_q, ovr_q;
  logic start, live, got, fin, expire;
  logic [DATA_W-1:0] res;
  adc_scan_next_ch #(.NUM_CH(NUM_CH)) u_next (
    .mask_i(mask_q), .idx_i(ch_q), .nxt_o(nxt_ch), .found_o(nxt_found)
  );
  adc_scan_next_ch #(.NUM_CH(NUM_CH)) u_first (
    .mask_i(ch_mask_i), .idx_i('0), .nxt_o(up_ch), .found_o(up_found)
  );
  assign first_ch = ch_mask_i[0] ? '0 : up_ch;
  assign start = state_q == IDLE && trig_i && |ch_mask_i;
`ifdef ADC_SCAN_AVG_EN
  localparam int unsigned AW = DATA_W + AVG_LOG2;
  logic [AVG_LOG2-1:0] smp_q;
  logic [AW-1:0] acc_q, acc_sum;
  logic gap_q;
  assign live = state_q == CONV && !gap_q;
  assign got = live && adc.adc_drdy;
  assign fin = got && &smp_q;
  assign acc_sum = acc_q + AW'(adc.adc_data);
  assign res = acc_sum[AVG_LOG2 +: DATA_W];
  // gap_q idles one cycle between samples so the wrapper sees a fresh start edge
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      smp_q <= '0;
      acc_q <= '0;
      gap_q <= 1'b0;
    end else begin
      gap_q <= got && !fin;
      smp_q <= state_q != CONV ? '0 : got ? smp_q + 1'b1 : smp_q;
      acc_q <= state_q != CONV || fin ? '0 : got ? acc_sum : acc_q;
    end
`else
  assign live = state_q == CONV;
  assign got = live && adc.adc_drdy;
  assign fin = got;
  assign res = adc.adc_data;
`endif
  assign expire = live && !adc.adc_drdy && wait_q == TW'(TIMEOUT_CYCLES - 1);
  assign ch_d = start ? first_ch : state_q == STORE && nxt_found ? nxt_ch : ch_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q == IDLE  ? (start ? CONV : IDLE)
            : state_q == CONV  ? (fin || expire ? STORE : CONV)
            : state_q == STORE ? (nxt_found ? CONV : DONE)
            : IDLE;
  end
  always_comb begin
    adc.adc_start = live;
    adc.adc_channel = ch_q;
    busy_o = state_q != IDLE;
    scan_done_o = state_q == DONE;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      mask_q <= '0;
      ch_q <= '0;
      wait_q <= '0;
      meas_q <= '0;
      valid_q <= '0;
      timeout_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      if (start) mask_q <= ch_mask_i;
      ch_q <= ch_d;
      wait_q <= live && !got ? wait_q + 1'b1 : '0;
      if (fin) meas_q[int'(ch_q)*DATA_W +: DATA_W] <= res;
      if (fin) valid_q[ch_q] <= 1'b1;
      else if (expire) valid_q[ch_q] <= 1'b0;
      timeout_q <= expire | (timeout_q & ~err_clr_i);
      ovr_q <= (trig_i && state_q != IDLE) | (ovr_q & ~err_clr_i);
    end
  assign meas_o = meas_q;
  assign meas_valid_o = valid_q;
  assign timeout_o = timeout_q;
  assign trig_ovr_o = ovr_q;
endmodule
